// File: rtl/booth_seq_multiplier.sv
// -----------------------------------------------------------------------------
// booth_seq_multiplier
//   Sequential radix-4 Booth multiplier for the MIPS mult/multu path.
//   One Booth digit is retired per clock; a WIDTH x WIDTH product takes
//   ITER = WIDTH/2+1 RUN cycles followed by a single DONE cycle.
//
// Handshake:
//   Start is sampled only in IDLE (Busy=0). On acceptance A, B and Signed
//   are latched and later changes on those inputs are ignored. Busy is high
//   in RUN and DONE. Done is a one-cycle pulse in DONE, in the same cycle
//   that Hi/Lo first show the new product. A Start seen while Busy=1 is
//   dropped (neither queued nor restarting).
//
// Ports:
//   CLK         in   rising-edge clock
//   RSTn        in   asynchronous active-low reset
//   Start       in   operation request
//   Signed      in   1 = signed (mult), 0 = unsigned (multu)
//   A           in   multiplicand [WIDTH-1:0]
//   B           in   multiplier   [WIDTH-1:0]
//   Busy        out  operation in flight (RUN or DONE)
//   Done        out  one-cycle result-valid pulse
//   Hi          out  upper half of product, held until next result
//   Lo          out  lower half of product, held until next result
//   dbg_state_o out  current FSM state (0=IDLE, 1=RUN, 2=DONE)
// -----------------------------------------------------------------------------
module booth_seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic [1:0]       dbg_state_o
);

  localparam int ITER  = WIDTH / 2 + 1;
  // Operands are extended by two bits so that multu of an operand with the
  // MSB set still sees a positive value in the top Booth digit.
  localparam int XW    = WIDTH + 2;
  // Headroom beyond 2*WIDTH keeps the shifted multiples from wrapping into
  // the product bits; only acc[2*WIDTH-1:0] is ever reported.
  localparam int ACC_W = 2 * WIDTH + 4;
  localparam int CW    = $clog2(ITER + 1);
  localparam logic [CW-1:0] LAST_DIGIT = CW'(ITER - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [XW-1:0]    mcand_q;   // extended multiplicand
  logic [XW:0]      mplier_q;  // {extended multiplier, Bx[-1]=0}, shifted right 2 per digit
  logic [CW-1:0]    cnt_q;     // digit index being processed
  logic [ACC_W-1:0] acc_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             busy_q;
  logic             done_q;

  // ---------------------------------------------------------------------------
  // Operand extension at acceptance
  // ---------------------------------------------------------------------------
  logic [XW-1:0] a_ext;
  logic [XW-1:0] b_ext;

  always_comb begin
    a_ext = Signed ? {{2{A[WIDTH-1]}}, A} : {2'b00, A};
    b_ext = Signed ? {{2{B[WIDTH-1]}}, B} : {2'b00, B};
  end

  // ---------------------------------------------------------------------------
  // Booth digit encode, multiple select and accumulate
  // ---------------------------------------------------------------------------
  logic [2:0]       triplet;
  logic             sel_one;
  logic             sel_two;
  logic             neg;
  logic [XW:0]      multiple;
  logic [ACC_W-1:0] mult_ext;
  logic [ACC_W-1:0] shifted;
  logic [ACC_W-1:0] addend;
  logic [ACC_W-1:0] acc_d;

  always_comb begin
    // The low three bits of the shifting multiplier register are always
    // {Bx[2i+1], Bx[2i], Bx[2i-1]} for the current digit i.
    triplet = mplier_q[2:0];
    sel_one = 1'b0;
    sel_two = 1'b0;
    neg     = 1'b0;
    case (triplet)
      3'b001, 3'b010: sel_one = 1'b1;
      3'b011:         sel_two = 1'b1;
      3'b100:         begin sel_two = 1'b1; neg = 1'b1; end
      3'b101, 3'b110: begin sel_one = 1'b1; neg = 1'b1; end
      default:        ; // 000, 111 -> zero multiple
    endcase

    multiple = '0;
    if (sel_two)      multiple = {mcand_q, 1'b0};
    else if (sel_one) multiple = {mcand_q[XW-1], mcand_q};

    mult_ext = {{(ACC_W - XW - 1){multiple[XW]}}, multiple};
    shifted  = mult_ext << {cnt_q, 1'b0};

    // Subtraction as invert plus carry-in, like the shared adder/subtractor.
    addend = neg ? ~shifted : shifted;
    acc_d  = acc_q + addend + {{(ACC_W - 1){1'b0}}, neg};
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            mcand_q  <= a_ext;
            mplier_q <= {b_ext, 1'b0};
            cnt_q    <= '0;
            acc_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc_q    <= acc_d;
          mplier_q <= {2'b00, mplier_q[XW:2]};
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LAST_DIGIT) begin
            hi_q    <= acc_d[2*WIDTH-1:WIDTH];
            lo_q    <= acc_d[WIDTH-1:0];
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign Busy        = busy_q;
  assign Done        = done_q;
  assign Hi          = hi_q;
  assign Lo          = lo_q;
  assign dbg_state_o = state_q;

endmodule
